// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope: gate-driven attack/decay/sustain/release stepped on a programmable
// tick, scaling an unsigned 8-bit sample about the 128 mid-rail level.
module adsr_envelope #(
  parameter int unsigned prescale_width = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                sample_in,
  input  logic                      gate,
  input  logic [prescale_width-1:0] tick_divider,
  input  logic [7:0]                attack_rate,
  input  logic [7:0]                decay_rate,
  input  logic [7:0]                sustain_level,
  input  logic [7:0]                release_rate,
  output logic [7:0]                sample_out,
  output logic [7:0]                envelope,
  output logic [2:0]                env_state,
  output logic                      active
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAttack  = 3'd1,
    StDecay   = 3'd2,
    StSustain = 3'd3,
    StRelease = 3'd4
  } state_e;

  state_e                    state_q, state_d;
  logic [prescale_width-1:0] cnt_q, cnt_d;
  logic                      gate_q;
  logic [7:0]                env_q, env_d;
  logic [7:0]                sample_out_q, sample_out_d;
  logic                      tick, rise, fall;
  logic [8:0]                env9, sus9, attack_step, decay_step, release_step;
  logic [8:0]                attack_sum, decay_diff, release_diff;
  logic signed [8:0]         centred;
  logic signed [15:0]        product;

  function automatic logic [8:0] step_of(logic [7:0] rate);
    return (rate == 8'd0) ? 9'd255 : {1'b0, rate};
  endfunction

  // Counter past a lowered divider keeps counting and wraps through its full width.
  assign tick  = (cnt_q == tick_divider);
  assign cnt_d = tick ? '0 : cnt_q + prescale_width'(1);

  assign rise = gate & ~gate_q;
  assign fall = ~gate & gate_q;

  assign env9         = {1'b0, env_q};
  assign sus9         = {1'b0, sustain_level};
  assign attack_step  = step_of(attack_rate);
  assign decay_step   = step_of(decay_rate);
  assign release_step = step_of(release_rate);
  assign attack_sum   = env9 + attack_step;
  assign decay_diff   = env9 - decay_step;
  assign release_diff = env9 - release_step;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Gate edges win over a coincident tick: the state moves and the envelope holds.
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (rise || fall) begin
      if (rise && (state_q == StIdle || state_q == StRelease)) begin
        state_d = StAttack;
      end else if (fall && (state_q inside {StAttack, StDecay, StSustain})) begin
        state_d = StRelease;
      end
    end else if (tick) begin
      unique case (state_q)
        StIdle: env_d = '0;
        StAttack: begin
          if (attack_sum >= 9'd255) begin
            env_d   = 8'd255;
            state_d = StDecay;
          end else begin
            env_d = attack_sum[7:0];
          end
        end
        StDecay: begin
          if ((env9 <= sus9 + decay_step) || (sus9 >= env9)) begin
            env_d   = sustain_level;
            state_d = StSustain;
          end else begin
            env_d = decay_diff[7:0];
          end
        end
        StSustain: env_d = sustain_level;
        StRelease: begin
          if (env9 <= release_step) begin
            env_d   = '0;
            state_d = StIdle;
          end else begin
            env_d = release_diff[7:0];
          end
        end
        default: begin
          env_d   = '0;
          state_d = StIdle;
        end
      endcase
    end
  end

  // Product spans -32640..32385, so 16 signed bits suffice and the shifted result fits 8.
  assign centred      = $signed({1'b0, sample_in} - 9'd128);
  assign product      = centred * $signed({1'b0, env_q});
  assign sample_out_d = 8'(product >>> 8) + 8'd128;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      gate_q       <= 1'b0;
      env_q        <= '0;
      sample_out_q <= 8'd128;
    end else begin
      cnt_q        <= cnt_d;
      gate_q       <= gate;
      env_q        <= env_d;
      sample_out_q <= sample_out_d;
    end
  end

  always_comb begin
    env_state  = state_q;
    active     = (state_q != StIdle);
    envelope   = env_q;
    sample_out = sample_out_q;
  end

endmodule

// File: tb/tb_adsr_envelope.sv
// Bench for adsr_envelope: directed ADSR/scaling/retrigger/prescaler scenarios plus randomized
// traffic, all checked cycle by cycle against an integer behavioural model.
module tb_adsr_envelope;
  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         gate;
  logic [7:0]   sample_in, attack_rate, decay_rate, sustain_level, release_rate;
  logic [W-1:0] tick_divider;
  logic [7:0]   sample_out, envelope;
  logic [2:0]   env_state;
  logic         active;

  int n_run  = 0;
  int n_fail = 0;

  // Model state: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release.
  int m_cnt, m_gate_d, m_state, m_env, m_out;

  always #5 clk = ~clk;

  adsr_envelope #(.prescale_width(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .gate         (gate),
    .tick_divider (tick_divider),
    .attack_rate  (attack_rate),
    .decay_rate   (decay_rate),
    .sustain_level(sustain_level),
    .release_rate (release_rate),
    .sample_out   (sample_out),
    .envelope     (envelope),
    .env_state    (env_state),
    .active       (active)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input int expv);
    n_run++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int step_of(input int rate);
    return (rate == 0) ? 255 : rate;
  endfunction

  task automatic model_edge();
    int tick, rise, fall, p, new_out, sa, sd, sr, sus;
    if (reset) begin
      m_cnt = 0; m_gate_d = 0; m_state = 0; m_env = 0; m_out = 128;
      return;
    end
    p       = (int'(sample_in) - 128) * m_env;
    new_out = 128 + (p >>> 8);
    tick    = (m_cnt == int'(tick_divider)) ? 1 : 0;
    m_cnt   = tick ? 0 : (m_cnt + 1) % (1 << W);
    rise    = (gate && m_gate_d == 0) ? 1 : 0;
    fall    = (!gate && m_gate_d == 1) ? 1 : 0;
    sa  = step_of(int'(attack_rate));
    sd  = step_of(int'(decay_rate));
    sr  = step_of(int'(release_rate));
    sus = int'(sustain_level);
    if (rise || fall) begin
      if (rise && (m_state == 0 || m_state == 4)) m_state = 1;
      else if (fall && m_state >= 1 && m_state <= 3) m_state = 4;
    end else if (tick) begin
      case (m_state)
        0: m_env = 0;
        1: if (m_env + sa >= 255) begin m_env = 255; m_state = 2; end else m_env += sa;
        2: if (m_env <= sus + sd || sus >= m_env) begin m_env = sus; m_state = 3; end
           else m_env -= sd;
        3: m_env = sus;
        default: if (m_env <= sr) begin m_env = 0; m_state = 0; end else m_env -= sr;
      endcase
    end
    m_gate_d = gate ? 1 : 0;
    m_out    = new_out;
  endtask

  task automatic run_cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("sample_out", sample_out, m_out);
    check_eq("envelope", envelope, m_env);
    check_eq("env_state", env_state, m_state);
    check_eq("active", active, (m_state != 0) ? 1 : 0);
  endtask

  task automatic set_rates(input int div, input int a, input int d, input int s, input int r);
    tick_divider  = W'(div);
    attack_rate   = 8'(a);
    decay_rate    = 8'(d);
    sustain_level = 8'(s);
    release_rate  = 8'(r);
  endtask

  initial begin
    int adsr_env[10] = '{0, 64, 128, 192, 255, 223, 191, 159, 128, 128};
    int adsr_st[10]  = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3};
    int rel_env[9]   = '{128, 112, 96, 80, 64, 48, 32, 16, 0};
    int scale_in[3]  = '{255, 0, 128};
    int scale_out[3] = '{254, 0, 128};

    // Reset held with random inputs and gate high.
    reset     = 1'b1;
    gate      = 1'b1;
    sample_in = 8'($urandom);
    set_rates($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 255), $urandom_range(0, 255));
    repeat (3) begin
      run_cycle();
      sample_in = 8'($urandom);
    end
    check_eq("rst_sample_out", sample_out, 128);
    check_eq("rst_envelope", envelope, 0);
    check_eq("rst_state", env_state, 0);
    check_eq("rst_active", active, 0);
    reset = 1'b0;
    run_cycle();
    check_eq("rst_release_rise", env_state, 1);

    // Full ADSR at tick every cycle.
    reset = 1'b1;
    gate  = 1'b0;
    set_rates(0, 64, 32, 128, 16);
    sample_in = 8'd200;
    run_cycle();
    reset = 1'b0;
    run_cycle();
    gate = 1'b1;
    for (int i = 0; i < 10; i++) begin
      run_cycle();
      check_eq("adsr_env", envelope, adsr_env[i]);
      check_eq("adsr_state", env_state, adsr_st[i]);
    end
    gate = 1'b0;
    for (int i = 0; i < 9; i++) begin
      run_cycle();
      check_eq("release_env", envelope, rel_env[i]);
      check_eq("release_state", env_state, (i == 8) ? 0 : 4);
    end
    check_eq("release_active", active, 0);

    // Scaling at full and half envelope.
    set_rates(0, 0, 32, 255, 16);
    gate = 1'b1;
    repeat (3) run_cycle();
    check_eq("scale_sustain_state", env_state, 3);
    check_eq("scale_sustain_env", envelope, 255);
    for (int i = 0; i < 3; i++) begin
      sample_in = 8'(scale_in[i]);
      run_cycle();
      check_eq("scale_full", sample_out, scale_out[i]);
    end
    sustain_level = 8'd128;
    sample_in     = 8'd128;
    run_cycle();
    check_eq("sustain_track", envelope, 128);
    sample_in = 8'd255;
    run_cycle();
    check_eq("scale_half_hi", sample_out, 191);
    sample_in = 8'd0;
    run_cycle();
    check_eq("scale_half_lo", sample_out, 64);

    // Retrigger from release at 100; the rise cycle is also a tick.
    set_rates(0, 64, 32, 128, 28);
    gate = 1'b0;
    run_cycle();
    run_cycle();
    check_eq("retrig_pre_env", envelope, 100);
    check_eq("retrig_pre_state", env_state, 4);
    gate = 1'b1;
    run_cycle();
    check_eq("retrig_hold_env", envelope, 100);
    check_eq("retrig_hold_state", env_state, 1);
    run_cycle();
    check_eq("retrig_step", envelope, 164);

    // Abort attack at 128.
    release_rate = 8'd0;
    gate = 1'b0;
    repeat (2) run_cycle();
    check_eq("abort_idle", env_state, 0);
    gate = 1'b1;
    repeat (3) run_cycle();
    gate = 1'b0;
    run_cycle();
    check_eq("abort_state", env_state, 4);
    check_eq("abort_env", envelope, 128);
    release_rate = 8'd16;
    run_cycle();
    check_eq("abort_release", envelope, 112);

    // Prescaler with divider 3, then reset mid-attack.
    release_rate = 8'd0;
    run_cycle();
    set_rates(3, 10, 32, 128, 16);
    sample_in = 8'd255;
    gate = 1'b1;
    run_cycle();
    for (int k = 1; k <= 12; k++) begin
      run_cycle();
      check_eq("prescale_env", envelope, 10 * ((k + 1) / 4));
    end
    reset = 1'b1;
    run_cycle();
    check_eq("midnote_rst_state", env_state, 0);
    check_eq("midnote_rst_env", envelope, 0);
    check_eq("midnote_rst_out", sample_out, 128);
    reset = 1'b0;

    // Randomized segments, each starting from reset so the prescaler begins at zero.
    for (int seg = 0; seg < 12; seg++) begin
      reset = 1'b1;
      gate  = 1'($urandom_range(0, 1));
      set_rates($urandom_range(0, 3), $urandom_range(0, 80), $urandom_range(0, 80),
                $urandom_range(0, 255), $urandom_range(0, 80));
      run_cycle();
      for (int c = 0; c < 150; c++) begin
        sample_in = 8'($urandom);
        if ($urandom_range(0, 19) == 0) gate = ~gate;
        if ($urandom_range(0, 29) == 0) sustain_level = 8'($urandom);
        reset = ($urandom_range(0, 299) == 0);
        run_cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
